// File: rtl/csa_carry_resolve_adder.sv
// Resolves the redundant sum/carry vectors from the CSA tree into a binary result, CHUNK bits per cycle.
// Latency: an operation accepted at edge k shows out_valid after edge k+NCHUNK; the tag travels with it.
// Backpressure: DONE holds result/cout/out_tag stable until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous abort of the operation in flight
//   in_valid/in_ready           input handshake for sum_vec, carry_vec, in_tag
//   out_valid/out_ready         output handshake for result, cout, out_tag
//   busy                        high while slices are being resolved
module csa_carry_resolve_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("csa_carry_resolve_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_sum;
  logic [WIDTH-1:0]   r_carry;
  logic [WIDTH-1:0]   r_result;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic               r_c;
  logic               r_cout;

  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic [CHUNK:0]     w_slice;

  // flush beats a pending accept, so a flushed in_valid in IDLE is dropped.
  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_step   = (r_state == S_BUSY) && !flush;
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

  // One slice of the carry-propagate add, with the ripple carry from the previous slice.
  assign w_slice = {1'b0, r_sum[int'(r_idx) * CHUNK +: CHUNK]}
                 + {1'b0, r_carry[int'(r_idx) * CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid)  w_next = S_BUSY;
        S_BUSY:  if (w_last)    w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default:                w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_carry  <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_c      <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_sum    <= sum_vec;
      r_carry  <= carry_vec;
      r_tag    <= in_tag;
      r_result <= '0;
      r_idx    <= '0;
      r_c      <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_step) begin
      r_result[int'(r_idx) * CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
      r_c   <= w_slice[CHUNK];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice[CHUNK];
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign result    = r_result;
  assign cout      = r_cout;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_csa_carry_resolve_adder.sv
// Scoreboard bench for csa_carry_resolve_adder: expected results are queued on issue and popped on out_valid.
// Latency: checks out_valid exactly NCHUNK cycles after accept and the spacing of back-to-back accepts.
// Backpressure: holds out_ready low in DONE and checks outputs stay frozen and inputs are ignored.
module tb_csa_carry_resolve_adder;
  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int TAG_W  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec = '0;
  logic [WIDTH-1:0] carry_vec = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  csa_carry_resolve_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present an operation for one cycle at a negedge (block assumed IDLE) and queue its reference result.
  task automatic drive_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input logic [TAG_W-1:0] t);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, s} + {1'b0, c};
    e.res = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.tag = t;
    exp_q.push_back(e);
    sum_vec = s; carry_vec = c; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if ({cout, result, out_tag} !== '0) begin n_bad++; $display("FAIL reset_outputs got=%b/%h/%h want=0", cout, result, out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_ripple();
    int n;
    exp_t e;
    drive_op({WIDTH{1'b1}}, 64'h1, 4'hA);
    wait_valid(n);
    n_cmp++; if (n !== NCHUNK) begin n_bad++; $display("FAIL ripple_latency got=%0d want=%0d", n, NCHUNK); end
    e = exp_q.pop_front();
    n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL ripple_result got=%h want=%h", result, e.res); end
    n_cmp++; if (cout !== e.co) begin n_bad++; $display("FAIL ripple_cout got=%b want=%b", cout, e.co); end
    n_cmp++; if (out_tag !== e.tag) begin n_bad++; $display("FAIL ripple_tag got=%h want=%h", out_tag, e.tag); end
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    int n;
    exp_t e;
    drive_op(64'h0000_0001_2345_6789, 64'h0000_0000_ABCD_0000, 4'h3);
    wait_valid(n);
    n_cmp++; if (n !== NCHUNK) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", n, NCHUNK); end
    e = exp_q.pop_front();
    n_cmp++; if (result !== 64'h0000_0001_CF12_6789) begin n_bad++; $display("FAIL basic_result got=%h want=%h", result, 64'h0000_0001_CF12_6789); end
    n_cmp++; if (cout !== e.co || out_tag !== e.tag) begin n_bad++; $display("FAIL basic_cout_tag got=%b/%h want=%b/%h", cout, out_tag, e.co, e.tag); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    out_ready = 1'b0;
    drive_op(64'hDEAD_BEEF_0000_FFFF, 64'hF00D_0000_FFFF_0001, 4'h5);
    wait_valid(n);
    n_cmp++; if (n !== NCHUNK) begin n_bad++; $display("FAIL bp_latency got=%0d want=%0d", n, NCHUNK); end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || cout !== e.co || out_tag !== e.tag) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got=%b/%b/%h/%b/%h want=1/0/%h/%b/%h", i, out_valid, in_ready, result, cout, out_tag, e.res, e.co, e.tag);
      end
      in_valid = i[0];
      sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; in_tag = 4'hF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got=%b/%b want=1/0", in_ready, out_valid); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_no_accept got=%b want=0", busy); end
  endtask

  task automatic test_flush();
    int n;
    int seen;
    exp_t e;
    drive_op({WIDTH{1'b1}}, {WIDTH{1'b1}}, 4'h7);
    @(negedge clk);
    @(negedge clk);
    // now resolving slice 2
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_back());
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle got=%b/%b/%b want=0/0/1", busy, out_valid, in_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_result got=%0d want=0", seen); end
    flush = 1'b1; in_valid = 1'b1; sum_vec = 64'h1; carry_vec = 64'h1; in_tag = 4'h1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_blocks_accept got=%b/%b want=0/1", busy, in_ready); end
    drive_op(64'h5, 64'h3, 4'h9);
    wait_valid(n);
    e = exp_q.pop_front();
    n_cmp++; if (n !== NCHUNK || result !== 64'h8 || cout !== e.co || out_tag !== e.tag) begin
      n_bad++; $display("FAIL flush_next_op got=%0d/%h/%b/%h want=%0d/%h/%b/%h", n, result, cout, out_tag, NCHUNK, 64'h8, e.co, e.tag);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n;
    int seen;
    exp_t e;
    drive_op({WIDTH{1'b1}}, 64'h1, 4'hC);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_immediate got=%b/%b/%b want=0/0/1", out_valid, busy, in_ready); end
    n_cmp++; if ({cout, result, out_tag} !== '0) begin n_bad++; $display("FAIL arst_outputs got=%b/%h/%h want=0", cout, result, out_tag); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL arst_no_stale got=%0d want=0", seen); end
    drive_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h2);
    wait_valid(n);
    e = exp_q.pop_front();
    n_cmp++; if (n !== NCHUNK || result !== 64'h0 || cout !== 1'b1 || out_tag !== e.tag) begin
      n_bad++; $display("FAIL arst_next_op got=%0d/%h/%b/%h want=%0d/0/1/%h", n, result, cout, out_tag, NCHUNK, e.tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 20;
    // Accept period: NCHUNK BUSY cycles, one DONE cycle, one IDLE cycle.
    localparam int PERIOD = NCHUNK + 2;
    int pushed, got, accepts, last_acc, budget;
    logic prev_acc;
    logic [WIDTH:0] full;
    exp_t e;
    out_ready = 1'b1;
    pushed = 0; got = 0; accepts = 0; last_acc = 0; budget = 0;
    sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; in_tag = 4'(pushed);
    full = {1'b0, sum_vec} + {1'b0, carry_vec};
    e.res = full[WIDTH-1:0]; e.co = full[WIDTH]; e.tag = in_tag;
    exp_q.push_back(e);
    pushed = 1;
    in_valid = 1'b1;
    prev_acc = in_ready && in_valid;
    while (got < NOPS && budget < 400) begin
      @(negedge clk);
      budget++;
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== e.res || cout !== e.co || out_tag !== e.tag) begin
          n_bad++; $display("FAIL b2b_result[%0d] got=%h/%b/%h want=%h/%b/%h", got, result, cout, out_tag, e.res, e.co, e.tag);
        end
        got++;
      end
      if (prev_acc) begin
        accepts++;
        if (accepts > 1) begin
          n_cmp++;
          if (cyc - last_acc !== PERIOD) begin n_bad++; $display("FAIL b2b_spacing got=%0d want=%0d", cyc - last_acc, PERIOD); end
        end
        last_acc = cyc;
        if (pushed < NOPS) begin
          sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; in_tag = 4'(pushed);
          full = {1'b0, sum_vec} + {1'b0, carry_vec};
          e.res = full[WIDTH-1:0]; e.co = full[WIDTH]; e.tag = in_tag;
          exp_q.push_back(e);
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      prev_acc = in_ready && in_valid;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== NOPS) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", got, NOPS); end
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_basic_add();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
